// File: rtl/tpg_defs.sv
// Shared encodings for the test pattern generator and its stream checker.
package tpg_defs;

  // Pattern modes; the generator and checker must agree on these.
  localparam logic [1:0] TPG_MODE_INC   = 2'd0;
  localparam logic [1:0] TPG_MODE_ROT   = 2'd1;
  localparam logic [1:0] TPG_MODE_ALT   = 2'd2;
  localparam logic [1:0] TPG_MODE_CONST = 2'd3;

  // Checker run states.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/tpg_expect_gen.sv
// Expected-word register with per-mode advance rules. Shared by the
// generator (as its data source) and the checker (as its reference).
module tpg_expect_gen
  import tpg_defs::*;
#(
  parameter int width = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [width-1:0] seed,
  input  logic [1:0]       mode,
  input  logic             advance,
  output logic [width-1:0] expected
);

  logic [width-1:0] expected_q, expected_d;
  logic [1:0]       mode_q, mode_d;

  // Next word: load wins over advance; idle cycles hold the current word.
  always_comb begin
    expected_d = expected_q;
    mode_d     = mode_q;
    if (load) begin
      expected_d = seed;
      mode_d     = mode;
    end else if (advance) begin
      case (mode_q)
        TPG_MODE_INC:   expected_d = expected_q + 1'b1;
        TPG_MODE_ROT:   expected_d = {expected_q[width-2:0], expected_q[width-1]};
        // Inverting the current word alternates seed / ~seed.
        TPG_MODE_ALT:   expected_d = ~expected_q;
        default:        expected_d = expected_q;
      endcase
    end
  end

  // Expected-word and latched-mode registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      expected_q <= '0;
      mode_q     <= TPG_MODE_INC;
    end else begin
      expected_q <= expected_d;
      mode_q     <= mode_d;
    end
  end

  assign expected = expected_q;

endmodule

// File: rtl/tpg_stream_checker.sv
// Sink-side checker: compares each accepted beat against the regenerated
// pattern and reports error count, first failing beat and pass/done.
module tpg_stream_checker
  import tpg_defs::*;
#(
  parameter int width = 32,
  parameter int cntw  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [width-1:0] seed,
  input  logic [cntw-1:0]  length,
  input  logic             in_valid,
  input  logic [width-1:0] in_data,
  output logic             in_ready,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [cntw-1:0]  err_count,
  output logic [cntw-1:0]  first_err_idx,
  output logic [width-1:0] first_err_data
);

  logic [1:0]       state_q, state_d;
  logic [cntw-1:0]  remaining_q, remaining_d;
  logic [cntw-1:0]  idx_q, idx_d;
  logic [cntw-1:0]  err_q, err_d;
  logic             ferr_seen_q, ferr_seen_d;
  logic [cntw-1:0]  ferr_idx_q, ferr_idx_d;
  logic [width-1:0] ferr_data_q, ferr_data_d;

  logic             load;
  logic             accept;
  logic             mismatch;
  logic [width-1:0] expected;

  // A start during RUN is ignored, so only IDLE/DONE can reload.
  assign load     = start && (state_q != ST_RUN);
  assign accept   = in_valid && (state_q == ST_RUN);
  assign mismatch = accept && (in_data != expected);

  tpg_expect_gen #(.width(width)) u_expect (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .seed     (seed),
    .mode     (mode),
    .advance  (accept),
    .expected (expected)
  );

  // Run control, beat counters and first-error capture.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    idx_d       = idx_q;
    err_d       = err_q;
    ferr_seen_d = ferr_seen_q;
    ferr_idx_d  = ferr_idx_q;
    ferr_data_d = ferr_data_q;
    if (load) begin
      remaining_d = length;
      idx_d       = '0;
      err_d       = '0;
      ferr_seen_d = 1'b0;
      ferr_idx_d  = '0;
      ferr_data_d = '0;
      state_d     = (length != '0) ? ST_RUN : ST_DONE;
    end else if (accept) begin
      remaining_d = remaining_q - 1'b1;
      idx_d       = idx_q + 1'b1;
      if (mismatch) begin
        if (err_q != '1) begin
          err_d = err_q + 1'b1;
        end
        if (!ferr_seen_q) begin
          ferr_seen_d = 1'b1;
          ferr_idx_d  = idx_q;
          ferr_data_d = in_data;
        end
      end
      if (remaining_q == {{(cntw-1){1'b0}}, 1'b1}) begin
        state_d = ST_DONE;
      end
    end
  end

  // State registers; reset discards any partial run.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      idx_q       <= '0;
      err_q       <= '0;
      ferr_seen_q <= 1'b0;
      ferr_idx_q  <= '0;
      ferr_data_q <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      idx_q       <= idx_d;
      err_q       <= err_d;
      ferr_seen_q <= ferr_seen_d;
      ferr_idx_q  <= ferr_idx_d;
      ferr_data_q <= ferr_data_d;
    end
  end

  assign in_ready       = (state_q == ST_RUN);
  assign busy           = (state_q == ST_RUN);
  assign done           = (state_q == ST_DONE);
  assign pass           = (state_q == ST_DONE) && (err_q == '0);
  assign err_count      = err_q;
  assign first_err_idx  = ferr_idx_q;
  assign first_err_data = ferr_data_q;

endmodule

// File: doc/tpg_stream_checker.md
# tpg_stream_checker

Receive-side checker for the test pattern generator's data stream. It accepts a valid/ready beat stream and regenerates the expected word for each beat from the same seed and mode the generator used. Each received word is compared against its expected value, and the block reports a saturating error count, the first failing beat, and a pass/done verdict. It sits at the sink end of the pattern link, either in loopback in the pcore or on the far side of a memory/FIFO path under test.

## Interface
Parameters:
- width, 32, data word width in bits (≥2).
- cntw, 16, width of the length, error-count and beat-index fields.

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse; loads configuration and begins a check run.
- mode  input  2  pattern: 0 increment, 1 walking-rotate, 2 alternate-invert, 3 constant. Sampled at start.
- seed  input  width  first expected word. Sampled at start.
- length  input  cntw  number of beats to check. Sampled at start.
- in_valid  input  1  a stream beat is present.
- in_data  input  width  stream beat payload.
- in_ready  output  1  the checker accepts a beat this cycle.
- busy  output  1  a run is in progress.
- done  output  1  the run is complete; held until the next start or reset.
- pass  output  1  valid when done=1; 1 iff err_count==0.
- err_count  output  cntw  mismatching beats seen; saturates at all-ones.
- first_err_idx  output  cntw  0-based index of the first mismatching beat.
- first_err_data  output  width  in_data of the first mismatching beat.

## Operation
- States: IDLE, RUN, DONE.
  - reset forces IDLE from any state.
- IDLE or DONE, start=1:
  - clear err_count, first_err_idx, first_err_data, the first-error flag and the beat index.
  - load expected←seed, remaining←length, latch mode.
  - next state: RUN if length≠0, else DONE.
- RUN:
  - in_ready=1 and busy=1.
  - A beat is accepted when in_valid & in_ready.
  - On each accepted beat:
    - compare in_data against expected over the full width, with bitwise equality.
    - on mismatch: increment err_count (saturating); if this is the first mismatch, capture the beat index into first_err_idx and in_data into first_err_data.
    - advance expected, increment the beat index, decrement remaining.
  - When remaining==1 and a beat is accepted, the next state is DONE.
- Expected-word advance rules:
  - mode 0: expected+1, modulo 2^width; all-ones wraps to 0.
  - mode 1: rotate left by 1; the MSB moves to bit 0.
  - mode 2: alternate seed, ~seed, seed, …
  - mode 3: seed on every beat.
- start while in RUN is ignored.
- DONE: done=1; pass = (err_count==0); in_ready=0.
- Beats offered outside RUN are not accepted and have no effect.

## Timing
- Reset values: in_ready=0, busy=0, done=0, pass=0, err_count=0, first_err_idx=0, first_err_data=0.
- State entry:
  - start at edge N → busy=1 and in_ready=1 from cycle N+1.
  - start with length=0 → done=1, pass=1 from cycle N+1.
- The compare uses the current expected register, with no pipeline stage. err_count and first_err_* update at the same edge that accepts the beat.
- Last beat accepted at edge M:
  - done=1 from cycle M+1.
  - in_ready=0 from cycle M+1.
  - err_count is final at M+1.
- Throughput is one beat per cycle; in_valid may toggle arbitrarily, and idle cycles do not advance expected.
- reset asserted during RUN returns all outputs to their reset values on the next cycle, discarding the partial run.
- The index counter is cntw bits; with length ≤ 2^cntw−1 it never wraps.

## Structure
- Shared package/include tpg_defs holds:
  - mode encodings TPG_MODE_INC, TPG_MODE_ROT, TPG_MODE_ALT, TPG_MODE_CONST;
  - state encodings IDLE/RUN/DONE.
- The generator uses the same package so both ends agree on the modes.
- Sub-module tpg_expect_gen (parameter width) contains the expected-word register and advance logic. Its inputs are load, seed, mode and advance; its output is expected. The generator pcore reuses it as its data source.
- The top level holds the FSM, counters, compare and first-error capture.

## Test plan
- Clean increment run: mode=0, seed=32'hFFFF_FFFE, length=4, data FFFF_FFFE, FFFF_FFFF, 0, 1 → done one cycle after the 4th beat, pass=1, err_count=0.
- Injected errors: mode=1, seed=1, length=8, beats 2 and 5 bit-flipped → err_count=2, first_err_idx=2, first_err_data equal to the corrupted beat 2, pass=0.
- Backpressure/gaps: mode=2, seed=32'hA5A5_0F0F, length=6, in_valid asserted one cycle in three → expected advances only on accepted beats, pass=1.
- Zero length and ignored restart:
  - start with length=0 → done=1, pass=1 at N+1.
  - start pulsed during a later RUN → no reload; the run completes normally.
- Reset mid-run: mode=3, length=10, 2 error beats, reset after beat 5 → all outputs 0 the next cycle; a subsequent clean run passes with err_count=0.
- Saturation: cntw=4, length=15, every beat wrong → err_count=4'hF, first_err_idx=0.
